phasenoisepon_segment_checker: RTL and testbench

//  Receive-side monitor for the seven-segment seconds display bus. Samples the 7 segment lines,

---
 rtl/phasenoisepon_segment_checker.sv | 215 +++++++++++++++++++++
 tb/tb_phasenoisepon_segment_checker.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/phasenoisepon_segment_checker.sv
// Seven-segment seconds-display monitor: synchronises and debounces the segment bus, decodes
// digits, measures clocks between changes and raises sticky sequence/timing/illegal flags.
//   state | meaning
//   SYNC  | no trusted digit yet, waiting for first legal pattern
//   ALIGN | one digit seen, interval since it is partial and unchecked
//   TRACK | full intervals measured and checked against the period window
module phasenoisepon_segment_checker #(
    parameter int unsigned PERIOD = 101,
    parameter int unsigned TOL    = 1,
    parameter int unsigned STABLE = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  segments,
    input  logic        clr_err,
    output logic [3:0]  digit,
    output logic        digit_valid,
    output logic        change,
    output logic [15:0] period,
    output logic        period_valid,
    output logic        seq_err,
    output logic        timing_err,
    output logic        illegal_err
);

    localparam int unsigned STAB_W = (STABLE < 2) ? 1 : $clog2(STABLE + 1);
    localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE);
    localparam logic [15:0] WIN_LO    = 16'(PERIOD - TOL);
    localparam logic [15:0] WIN_HI    = 16'(PERIOD + TOL);
    localparam logic [15:0] STALL_CNT = 16'(PERIOD + TOL + 1);
    localparam logic [15:0] CNT_MAX   = 16'hFFFF;

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        ALIGN = 2'd1,
        TRACK = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [6:0]        s1_q, s2_q, prev_q, acc_q;
    logic [6:0]        acc_d;
    logic [STAB_W-1:0] stab_q, stab_d;
    logic [15:0]       cnt_q, cnt_d;

    logic [3:0]  digit_q, digit_d;
    logic        digit_valid_q, digit_valid_d;
    logic        change_q, change_d;
    logic [15:0] period_q, period_d;
    logic        period_valid_q, period_valid_d;
    logic        seq_err_q, seq_err_d;
    logic        timing_err_q, timing_err_d;
    logic        illegal_err_q, illegal_err_d;

    logic        accept;
    logic        legal;
    logic [3:0]  dec_digit;
    logic [3:0]  exp_next;
    logic        in_window;

    function automatic logic [4:0] decode(input logic [6:0] p);
        logic [4:0] r;
        case (p)
            7'b0111111: r = {1'b1, 4'd0};
            7'b0000110: r = {1'b1, 4'd1};
            7'b1011011: r = {1'b1, 4'd2};
            7'b1001111: r = {1'b1, 4'd3};
            7'b1100110: r = {1'b1, 4'd4};
            7'b1101101: r = {1'b1, 4'd5};
            7'b1111100: r = {1'b1, 4'd6};
            7'b0000111: r = {1'b1, 4'd7};
            7'b1111111: r = {1'b1, 4'd8};
            7'b1100111: r = {1'b1, 4'd9};
            default:    r = {1'b0, 4'd0};
        endcase
        return r;
    endfunction

    // Glitch filter: a pattern is accepted once it has held STABLE samples and is new.
    always_comb begin
        stab_d = STAB_W'(1);
        if (s2_q == prev_q) begin
            if (stab_q >= STAB_MAX) begin
                stab_d = STAB_MAX;
            end else begin
                stab_d = stab_q + 1'b1;
            end
        end
        accept = (stab_d == STAB_MAX) && (s2_q != acc_q);
        acc_d  = accept ? s2_q : acc_q;
    end

    always_comb begin
        {legal, dec_digit} = decode(s2_q);
        exp_next  = (digit_q == 4'd9) ? 4'd0 : digit_q + 4'd1;
        in_window = (cnt_q >= WIN_LO) && (cnt_q <= WIN_HI);
    end

    always_comb begin
        cnt_d = cnt_q;
        if (accept) begin
            cnt_d = 16'd1;
        end else if (state_q != SYNC && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q   <= 7'd0;
            s2_q   <= 7'd0;
            prev_q <= 7'd0;
            acc_q  <= 7'd0;
            stab_q <= '0;
            cnt_q  <= 16'd0;
        end else begin
            s1_q   <= segments;
            s2_q   <= s1_q;
            prev_q <= s2_q;
            acc_q  <= acc_d;
            stab_q <= stab_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (accept) begin
            if (!legal) begin
                state_d = SYNC;
            end else begin
                case (state_q)
                    SYNC:    state_d = ALIGN;
                    ALIGN:   state_d = TRACK;
                    TRACK:   state_d = TRACK;
                    default: state_d = SYNC;
                endcase
            end
        end
    end

    // Sticky flags: clear first so a coincident set event wins.
    always_comb begin
        digit_d        = digit_q;
        digit_valid_d  = digit_valid_q;
        change_d       = 1'b0;
        period_d       = period_q;
        period_valid_d = 1'b0;
        seq_err_d      = seq_err_q     & ~clr_err;
        timing_err_d   = timing_err_q  & ~clr_err;
        illegal_err_d  = illegal_err_q & ~clr_err;
        if (accept) begin
            if (!legal) begin
                illegal_err_d = 1'b1;
                digit_valid_d = 1'b0;
            end else begin
                digit_d       = dec_digit;
                digit_valid_d = 1'b1;
                change_d      = 1'b1;
                if (state_q != SYNC && dec_digit != exp_next) begin
                    seq_err_d = 1'b1;
                end
                if (state_q == TRACK) begin
                    period_d       = cnt_q;
                    period_valid_d = 1'b1;
                    if (!in_window) begin
                        timing_err_d = 1'b1;
                    end
                end
            end
        end else if (state_q == TRACK && cnt_q == STALL_CNT) begin
            timing_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit_q        <= 4'd0;
            digit_valid_q  <= 1'b0;
            change_q       <= 1'b0;
            period_q       <= 16'd0;
            period_valid_q <= 1'b0;
            seq_err_q      <= 1'b0;
            timing_err_q   <= 1'b0;
            illegal_err_q  <= 1'b0;
        end else begin
            digit_q        <= digit_d;
            digit_valid_q  <= digit_valid_d;
            change_q       <= change_d;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
            seq_err_q      <= seq_err_d;
            timing_err_q   <= timing_err_d;
            illegal_err_q  <= illegal_err_d;
        end
    end

    assign digit        = digit_q;
    assign digit_valid  = digit_valid_q;
    assign change       = change_q;
    assign period       = period_q;
    assign period_valid = period_valid_q;
    assign seq_err      = seq_err_q;
    assign timing_err   = timing_err_q;
    assign illegal_err  = illegal_err_q;

endmodule

// File: tb/tb_phasenoisepon_segment_checker.sv
// Directed bench for phasenoisepon_segment_checker: expected digit changes are queued when
// patterns are driven and compared when the change pulse appears.
module tb_phasenoisepon_segment_checker;

    logic        clk;
    logic        rst;
    logic [6:0]  segments;
    logic        clr_err;
    logic [3:0]  digit;
    logic        digit_valid;
    logic        change;
    logic [15:0] period;
    logic        period_valid;
    logic        seq_err;
    logic        timing_err;
    logic        illegal_err;

    typedef struct {
        logic [3:0] d;
        logic       pv;
        int         per;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   gap    = 0;
    int   sync_n = 0;

    phasenoisepon_segment_checker dut (
        .clk          (clk),
        .rst          (rst),
        .segments     (segments),
        .clr_err      (clr_err),
        .digit        (digit),
        .digit_valid  (digit_valid),
        .change       (change),
        .period       (period),
        .period_valid (period_valid),
        .seq_err      (seq_err),
        .timing_err   (timing_err),
        .illegal_err  (illegal_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b0111111;
            1: return 7'b0000110;
            2: return 7'b1011011;
            3: return 7'b1001111;
            4: return 7'b1100110;
            5: return 7'b1101101;
            6: return 7'b1111100;
            7: return 7'b0000111;
            8: return 7'b1111111;
            default: return 7'b1100111;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
        gap += n;
    endtask

    task automatic expect_change(input int d);
        exp_t e;
        e.d   = 4'(d);
        e.pv  = (sync_n >= 2);
        e.per = gap;
        q.push_back(e);
        sync_n++;
        gap = 0;
    endtask

    task automatic step(input int d, input int hold);
        expect_change(d);
        segments = seg_of(d);
        tick(hold);
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (change) begin
                check("change_expected", 32'(q.size() != 0), 32'd1);
                if (q.size() != 0) begin
                    exp_t e;
                    e = q.pop_front();
                    check("change_digit", 32'(digit), 32'(e.d));
                    check("change_period_valid", 32'(period_valid), 32'(e.pv));
                    if (e.pv) begin
                        check("change_period", 32'(period), 32'(e.per));
                    end
                end
            end else begin
                check("period_valid_without_change", 32'(period_valid), 32'd0);
            end
        end
    end

    initial begin
        rst      = 1'b1;
        segments = 7'd0;
        clr_err  = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(2);
        check("rst_digit", 32'(digit), 32'd0);
        check("rst_digit_valid", 32'(digit_valid), 32'd0);
        check("rst_change", 32'(change), 32'd0);
        check("rst_period", 32'(period), 32'd0);
        check("rst_period_valid", 32'(period_valid), 32'd0);
        check("rst_errs", 32'({seq_err, timing_err, illegal_err}), 32'd0);

        // Full 0..9,0 sweep at nominal period
        for (int i = 0; i < 11; i++) step(i % 10, 101);
        check("sweep_errs", 32'({seq_err, timing_err, illegal_err}), 32'd0);
        check("sweep_digit", 32'(digit), 32'd0);
        check("sweep_valid", 32'(digit_valid), 32'd1);

        // Skipped digit 3 -> 5
        step(1, 101);
        step(2, 101);
        step(3, 101);
        step(5, 100);
        check("skip_seq_err", 32'(seq_err), 32'd1);
        check("skip_timing_err", 32'(timing_err), 32'd0);
        check("skip_digit", 32'(digit), 32'd5);
        pulse_clr();
        check("skip_seq_cleared", 32'(seq_err), 32'd0);

        // Stall: hold 6 for 150 clocks
        step(6, 102);
        check("stall_not_yet", 32'(timing_err), 32'd0);
        tick(8);
        check("stall_timing_err", 32'(timing_err), 32'd1);
        tick(40);
        step(7, 100);
        check("stall_period", 32'(period), 32'd150);
        pulse_clr();
        check("stall_cleared", 32'({seq_err, timing_err}), 32'd0);

        // One-clock glitch, then an illegal stable pattern
        step(8, 50);
        segments = 7'd0;
        tick(1);
        segments = seg_of(8);
        tick(50);
        check("glitch_no_event", 32'(q.size()), 32'd0);
        check("glitch_digit", 32'(digit), 32'd8);
        segments = 7'b1010101;
        tick(10);
        sync_n = 0;
        check("illegal_err", 32'(illegal_err), 32'd1);
        check("illegal_digit_valid", 32'(digit_valid), 32'd0);
        check("illegal_digit_held", 32'(digit), 32'd8);
        pulse_clr();
        check("illegal_cleared", 32'(illegal_err), 32'd0);
        step(2, 101);
        check("resync_valid", 32'(digit_valid), 32'd1);
        check("resync_seq", 32'(seq_err), 32'd0);
        step(3, 101);

        // 9 -> 0 wrap at window edges and just outside
        for (int d = 4; d <= 8; d++) step(d, 101);
        step(9, 100);
        for (int d = 0; d <= 8; d++) step(d, 101);
        step(9, 102);
        step(0, 101);
        check("wrap_window_errs", 32'({seq_err, timing_err, illegal_err}), 32'd0);
        for (int d = 1; d <= 8; d++) step(d, 101);
        step(9, 99);
        step(0, 50);
        check("wrap_early_timing", 32'(timing_err), 32'd1);
        check("wrap_early_period", 32'(period), 32'd99);
        check("wrap_early_seq", 32'(seq_err), 32'd0);

        // Asynchronous reset mid-run
        rst = 1'b1;
        #1;
        check("midrst_outputs", 32'({digit, digit_valid, change, period_valid,
                                     seq_err, timing_err, illegal_err}), 32'd0);
        check("midrst_period", 32'(period), 32'd0);
        tick(2);
        rst    = 1'b0;
        sync_n = 0;
        expect_change(0);
        tick(1);
        check("midrst_not_valid_yet", 32'(digit_valid), 32'd0);
        tick(10);
        check("midrst_resync_valid", 32'(digit_valid), 32'd1);
        step(1, 101);
        check("midrst_errs", 32'({seq_err, timing_err, illegal_err}), 32'd0);
        tick(5);
        check("queue_drained", 32'(q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
